// File: rtl/fx3_burst_reader.sv
// Drains the 10-bit sample DCFIFO in fixed-size bursts toward the FX3 bridge.
// Each popped sample leaves one cycle later as a 16-bit word tagged with a 6-bit burst sequence.
module fx3_burst_reader #(
  parameter int BURST_WORDS   = 8192,
  parameter bit START_ON_HALF = 1'b1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [9:0]  fifoData,
  input  logic        fifoEmpty,
  input  logic        fifoHalfFull,
  input  logic        fifoFull,
  output logic        fifoAck,
  input  logic        fx3Ready,
  output logic [15:0] fx3Data,
  output logic        fx3Write,
  output logic        fx3PktEnd,
  output logic        overflowError,
  output logic        underrunError
);

  localparam int CW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] word_count;
  logic [CW-1:0] word_count_nx;
  logic [5:0]    seq;
  logic [5:0]    seq_nx;
  logic          start;
  logic          xfer;
  logic          last;

  always_comb begin
    state_nx      = state;
    word_count_nx = word_count;
    seq_nx        = seq;
    start         = START_ON_HALF ? fifoHalfFull : !fifoEmpty;
    xfer          = 1'b0;
    last          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = BURST;
      end
      BURST: begin
        xfer = !fifoEmpty && fx3Ready;
        last = xfer && (word_count == LAST);
        if (last) begin
          word_count_nx = '0;
          seq_nx        = seq + 6'd1;
          state_nx      = GAP;
        end else if (xfer) begin
          word_count_nx = word_count + 1'b1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The pop is gated by reset so a held reset never consumes samples.
  assign fifoAck = xfer && nReset;

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state         <= IDLE;
      word_count    <= '0;
      seq           <= '0;
      fx3Data       <= '0;
      fx3Write      <= 1'b0;
      fx3PktEnd     <= 1'b0;
      overflowError <= 1'b0;
      underrunError <= 1'b0;
    end else begin
      state      <= state_nx;
      word_count <= word_count_nx;
      seq        <= seq_nx;
      fx3Write   <= xfer;
      fx3PktEnd  <= last;
      if (xfer) fx3Data <= {seq, fifoData};
      if (fifoFull) overflowError <= 1'b1;
      if (state == BURST && fifoEmpty && word_count != '0)
        underrunError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx3_burst_reader.sv
// Randomized bench for fx3_burst_reader with BURST_WORDS=4.
// Reference: the n-th word popped since reset leaves as {n/4 mod 64, sample}, pktEnd on n mod 4 == 3.
module tb_fx3_burst_reader;

  localparam int BW = 4;

  logic        clock = 1'b0;
  logic        nReset;
  logic [9:0]  fifoData;
  logic        fifoEmpty;
  logic        fifoHalfFull;
  logic        fifoFull;
  logic        fifoAck;
  logic        fx3Ready;
  logic [15:0] fx3Data;
  logic        fx3Write;
  logic        fx3PktEnd;
  logic        overflowError;
  logic        underrunError;

  fx3_burst_reader #(.BURST_WORDS(BW), .START_ON_HALF(1'b1)) dut (
    .clock(clock),
    .nReset(nReset),
    .fifoData(fifoData),
    .fifoEmpty(fifoEmpty),
    .fifoHalfFull(fifoHalfFull),
    .fifoFull(fifoFull),
    .fifoAck(fifoAck),
    .fx3Ready(fx3Ready),
    .fx3Data(fx3Data),
    .fx3Write(fx3Write),
    .fx3PktEnd(fx3PktEnd),
    .overflowError(overflowError),
    .underrunError(underrunError)
  );

  always #5 clock = ~clock;

  logic [9:0]  fq[$];
  logic        force_empty;
  int          k;
  int          npop;
  int          passed = 0;
  int          total = 0;
  logic        obs_ack, ack_bad;
  logic        obs_wr, obs_pkt;
  logic [15:0] obs_data;
  logic        exp_wr, exp_pkt;
  logic [15:0] exp_data, last_data;

  // FIFO emulation plus output model for one clock cycle.
  task automatic step();
    logic [9:0] s;
    @(negedge clock);
    fifoEmpty    = force_empty || (fq.size() == 0);
    fifoData     = (fq.size() != 0) ? fq[0] : 10'h0;
    fifoHalfFull = (fq.size() >= 4);
    #1;
    obs_ack = fifoAck;
    ack_bad = obs_ack && (fifoEmpty || !fx3Ready || !nReset);
    @(posedge clock);
    exp_wr  = 1'b0;
    exp_pkt = 1'b0;
    if (!nReset) begin
      k = 0;
      last_data = '0;
    end else if (obs_ack && fq.size() != 0) begin
      s = fq.pop_front();
      npop++;
      exp_wr    = 1'b1;
      exp_pkt   = ((k % BW) == BW - 1);
      last_data = {6'((k / BW) % 64), s};
      k++;
    end
    exp_data = last_data;
    #1;
    obs_wr   = fx3Write;
    obs_pkt  = fx3PktEnd;
    obs_data = fx3Data;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    fq.delete();
    force_empty = 1'b0;
    fx3Ready = 1'b1;
    fifoFull = 1'b0;
    npop = 0;
    step();
    step();
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    fq.delete();
    force_empty = 1'b0;
    fx3Ready = 1'b1;
    fifoFull = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(10'(i));
    step();
    step();
    total++;
    if (obs_ack !== 1'b0) $display("FAIL reset_ack: got %0b want 0", obs_ack);
    else passed++;
    total++;
    if ({obs_wr, obs_pkt, obs_data} !== 18'h0)
      $display("FAIL reset_out: wr=%0b pkt=%0b data=%h want all 0", obs_wr, obs_pkt, obs_data);
    else passed++;
    total++;
    if ({overflowError, underrunError} !== 2'b00)
      $display("FAIL reset_err: got %b want 00", {overflowError, underrunError});
    else passed++;
    nReset = 1'b1;
  endtask

  task automatic test_ramp();
    int lastpkt;
    int gap_ok;
    do_reset();
    for (int i = 0; i < 10; i++) fq.push_back(10'(i));
    lastpkt = -1;
    gap_ok = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      total++;
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data)
        $display("FAIL ramp_word: wr=%0b/%0b pkt=%0b/%0b data=%h/%h ack_bad=%0b",
                 obs_wr, exp_wr, obs_pkt, exp_pkt, obs_data, exp_data, ack_bad);
      else passed++;
      if (obs_wr && lastpkt >= 0) begin
        total++;
        if (i - lastpkt !== 3) $display("FAIL ramp_gap: got %0d want 3", i - lastpkt);
        else passed++;
        gap_ok++;
        lastpkt = -1;
      end
      if (obs_pkt && obs_wr && k == BW) lastpkt = i;
    end
    total++;
    if (k !== 8 || fq.size() !== 2 || gap_ok !== 1)
      $display("FAIL ramp_count: words=%0d left=%0d gaps=%0d want 8 2 1", k, fq.size(), gap_ok);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 12; i++) fq.push_back(10'($urandom_range(0, 1023)));
    for (int i = 0; i < 20 && npop < 2; i++) begin
      step();
      total++;
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data)
        $display("FAIL stall_pre: wr=%0b/%0b data=%h/%h", obs_wr, exp_wr, obs_data, exp_data);
      else passed++;
    end
    fx3Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_ack !== 1'b0 || (i > 0 && obs_wr !== 1'b0))
        $display("FAIL stall_hold: ack=%0b wr=%0b want 0 0", obs_ack, obs_wr);
      else passed++;
    end
    fx3Ready = 1'b1;
    step();
    total++;
    if (obs_ack !== 1'b1 || obs_wr !== 1'b1 || obs_data !== exp_data)
      $display("FAIL stall_resume: ack=%0b wr=%0b data=%h want 1 1 %h", obs_ack, obs_wr, obs_data, exp_data);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      step();
      total++;
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data)
        $display("FAIL stall_word: wr=%0b/%0b pkt=%0b/%0b data=%h/%h",
                 obs_wr, exp_wr, obs_pkt, exp_pkt, obs_data, exp_data);
      else passed++;
    end
    total++;
    if (k !== 12 || fq.size() !== 0) $display("FAIL stall_count: got %0d want 12", k);
    else passed++;
  endtask

  task automatic test_underrun();
    do_reset();
    force_empty = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(10'($urandom_range(0, 1023)));
    for (int i = 0; i < 5; i++) step();
    total++;
    if (underrunError !== 1'b0 || npop !== 0)
      $display("FAIL underrun_start: err=%0b pops=%0d want 0 0", underrunError, npop);
    else passed++;
    force_empty = 1'b0;
    for (int i = 0; i < 20 && npop < 2; i++) step();
    total++;
    if (npop !== 2) $display("FAIL underrun_wait: pops=%0d want 2", npop);
    else passed++;
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_ack !== 1'b0) $display("FAIL underrun_ack: got %0b want 0", obs_ack);
      else passed++;
    end
    total++;
    if (underrunError !== 1'b1) $display("FAIL underrun_set: got %0b want 1", underrunError);
    else passed++;
    force_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data)
        $display("FAIL underrun_word: wr=%0b/%0b pkt=%0b/%0b data=%h/%h",
                 obs_wr, exp_wr, obs_pkt, exp_pkt, obs_data, exp_data);
      else passed++;
    end
    total++;
    if (k !== 8 || underrunError !== 1'b1)
      $display("FAIL underrun_end: words=%0d err=%0b want 8 1", k, underrunError);
    else passed++;
  endtask

  task automatic test_seq_wrap();
    int pushed;
    int bad;
    logic [5:0] tag65;
    do_reset();
    pushed = 0;
    bad = 0;
    tag65 = 6'h3f;
    for (int i = 0; i < 4000 && k < 260; i++) begin
      if (fq.size() < 6 && pushed < 260) begin
        fq.push_back(10'($urandom_range(0, 1023)));
        pushed++;
      end
      fx3Ready = ($urandom_range(0, 3) != 0);
      step();
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data) begin
        if (bad < 5)
          $display("FAIL seq_word: k=%0d wr=%0b/%0b pkt=%0b/%0b data=%h/%h",
                   k, obs_wr, exp_wr, obs_pkt, exp_pkt, obs_data, exp_data);
        bad++;
      end
      if (obs_wr && k == 257) tag65 = obs_data[15:10];
    end
    total++;
    if (bad != 0) $display("FAIL seq_words: %0d bad cycles want 0", bad);
    else passed++;
    total++;
    if (k !== 260) $display("FAIL seq_count: got %0d want 260", k);
    else passed++;
    total++;
    if (tag65 !== 6'd0) $display("FAIL seq_wrap: got %0d want 0", tag65);
    else passed++;
    fx3Ready = 1'b1;
  endtask

  task automatic test_overflow();
    do_reset();
    step();
    total++;
    if (overflowError !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", overflowError);
    else passed++;
    fifoFull = 1'b1;
    step();
    fifoFull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (overflowError !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflowError);
      else passed++;
    end
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    total++;
    if (overflowError !== 1'b0) $display("FAIL ovf_reset: got %0b want 0", overflowError);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int pkts;
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(10'($urandom_range(0, 1023)));
    for (int i = 0; i < 20 && npop < 2; i++) step();
    total++;
    if (npop !== 2) $display("FAIL rmid_wait: pops=%0d want 2", npop);
    else passed++;
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    total++;
    if (obs_ack !== 1'b0 || {obs_wr, obs_pkt, obs_data} !== 18'h0)
      $display("FAIL rmid_out: ack=%0b wr=%0b pkt=%0b data=%h want all 0",
               obs_ack, obs_wr, obs_pkt, obs_data);
    else passed++;
    pkts = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_pkt) pkts++;
      total++;
      if (ack_bad || obs_wr !== exp_wr || obs_pkt !== exp_pkt || obs_data !== exp_data)
        $display("FAIL rmid_word: wr=%0b/%0b pkt=%0b/%0b data=%h/%h",
                 obs_wr, exp_wr, obs_pkt, exp_pkt, obs_data, exp_data);
      else passed++;
    end
    total++;
    if (k !== 4 || pkts !== 1 || fq.size() !== 2)
      $display("FAIL rmid_count: words=%0d pkts=%0d left=%0d want 4 1 2", k, pkts, fq.size());
    else passed++;
  endtask

  initial begin
    nReset = 1'b0;
    fifoFull = 1'b0;
    fx3Ready = 1'b1;
    force_empty = 1'b0;
    fifoEmpty = 1'b1;
    fifoHalfFull = 1'b0;
    fifoData = '0;
    k = 0;
    npop = 0;
    last_data = '0;
    test_reset();
    test_ramp();
    test_stall();
    test_underrun();
    test_seq_wrap();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
